// File: rtl/bram_phase1_arbiter.sv
// -----------------------------------------------------------------------------
// bram_phase1_arbiter
//   Shares the single read port of one phase-1 lookup BRAM between NUM_REQ
//   lookup engines. A round-robin grant picks one requester per cycle. The
//   accepted address goes straight to the BRAM, and the result comes back one
//   cycle later, tagged with the requester index. Addresses at or above DEPTH
//   are not sent to the BRAM. They are answered with rsp_err=1 and data 0.
//
// Ports
//   clka        clock (shared with the BRAM)
//   rsta        synchronous reset, active-high
//   req_valid   per-requester request valid
//   req_ready   per-requester accept (one-hot or zero)
//   req_addr    packed request addresses; requester i uses [i*AW +: AW]
//   rsp_valid   response valid
//   rsp_ready   response accept
//   rsp_id      index of the requester that owns the response
//   rsp_data    lookup result (0 when rsp_err=1)
//   rsp_err     the request address was >= DEPTH
//   bram_ena    BRAM read enable
//   bram_addra  BRAM read address
//   bram_douta  BRAM read data (1-cycle latency)
// -----------------------------------------------------------------------------
module bram_phase1_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32768
) (
  input  logic                          clka,
  input  logic                          rsta,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic                          bram_ena,
  output logic [ADDR_WIDTH-1:0]         bram_addra,
  input  logic [DATA_WIDTH-1:0]         bram_douta
);

  localparam logic [ADDR_WIDTH-1:0] DEPTH_C = ADDR_WIDTH'(DEPTH);

  logic [ID_WIDTH-1:0]   ptr_r;        // index of the last accepted requester
  logic                  rsp_valid_r;
  logic [ID_WIDTH-1:0]   rsp_id_r;
  logic                  rsp_err_r;
  logic [ADDR_WIDTH-1:0] addr_last_r;  // address driven in the last granted cycle

  logic                  grant_vld_s;
  logic [ID_WIDTH-1:0]   grant_idx_s;
  logic [ADDR_WIDTH-1:0] grant_addr_s;
  logic                  issue_ok_s;
  logic                  accept_s;
  logic                  in_range_s;

  // Round-robin search: the scan runs from the farthest slot to the nearest
  // slot, so the nearest valid slot after ptr_r is the one that remains.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[(int'(ptr_r) + k) % NUM_REQ]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = ID_WIDTH'((int'(ptr_r) + k) % NUM_REQ);
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // Handshake decode and BRAM port drive for the granted requester.
  always_comb begin
    grant_addr_s = req_addr[int'(grant_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
    issue_ok_s   = !rsp_valid_r || rsp_ready;
    accept_s     = grant_vld_s && issue_ok_s && !rsta;
    in_range_s   = (grant_addr_s < DEPTH_C);
    req_ready    = '0;
    if (accept_s) begin
      req_ready[grant_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
    bram_ena = accept_s && in_range_s;
    if (grant_vld_s) begin
      bram_addra = grant_addr_s;
    end else begin
      bram_addra = addr_last_r;
    end
  end

  // Response data: the BRAM holds douta while ena=0, so the data is stable
  // for as long as the response is stalled.
  always_comb begin
    if (rsp_err_r) begin
      rsp_data = '0;
    end else begin
      rsp_data = bram_douta;
    end
    rsp_valid = rsp_valid_r;
    rsp_id    = rsp_id_r;
    rsp_err   = rsp_err_r;
  end

  // Pointer and response state. An accept overrides a consume in the same
  // cycle, which keeps one response in flight at full throughput.
  always_ff @(posedge clka) begin
    if (rsta) begin
      ptr_r       <= ID_WIDTH'(NUM_REQ - 1);
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      rsp_err_r   <= 1'b0;
    end else if (accept_s) begin
      ptr_r       <= grant_idx_s;
      rsp_valid_r <= 1'b1;
      rsp_id_r    <= grant_idx_s;
      rsp_err_r   <= !in_range_s;
    end else if (rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end else begin
      rsp_valid_r <= rsp_valid_r;
    end
  end

  // Keeps the address on the BRAM port steady when no one is granted.
  always_ff @(posedge clka) begin
    addr_last_r <= bram_addra;
  end

endmodule

// File: tb/tb_bram_phase1_arbiter.sv
module tb_bram_phase1_arbiter;
  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 32768;

  logic          clka = 1'b0;
  logic          rsta;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [NR*AW-1:0] req_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          bram_ena;
  logic [AW-1:0] bram_addra;
  logic [DW-1:0] bram_douta = 32'h0;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int          last_g;
  bit          exp_rv;
  int          exp_id;
  bit          exp_err;
  logic [31:0] exp_data;
  logic [31:0] exp_last;
  bit          last_known = 1'b0;
  int          last_acc;
  int          acc_log[$];

  bram_phase1_arbiter #(.NUM_REQ(NR), .ID_WIDTH(2), .ADDR_WIDTH(AW),
                        .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clka(clka), .rsta(rsta), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .bram_ena(bram_ena), .bram_addra(bram_addra), .bram_douta(bram_douta));

  always #5 clka = ~clka;

  function automatic logic [31:0] bram_fn(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h12345678;
  endfunction

  // BRAM model: one-cycle read latency, holds douta while ena is low
  always @(posedge clka) if (bram_ena) bram_douta <= bram_fn(bram_addra);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] addr_of(input int i);
    return req_addr[i*AW +: AW];
  endfunction

  task automatic set_addr(input int i, input logic [31:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  // One clock cycle: check against the model at negedge, then advance it at posedge
  task automatic cycle();
    int g;
    bit ok;
    bit acc;
    logic [31:0] ga;
    @(negedge clka);
    g = -1;
    for (int k = 1; k <= NR; k++) begin
      if (g < 0 && req_valid[(last_g + k) % NR]) g = (last_g + k) % NR;
    end
    ok  = !exp_rv || rsp_ready;
    acc = (g >= 0) && ok && !rsta;
    ga  = (g >= 0) ? addr_of(g) : 32'h0;
    chk("req_ready", 64'(req_ready), acc ? 64'(1 << g) : 64'h0);
    chk("bram_ena", 64'(bram_ena), 64'(acc && (ga < DEPTH)));
    if (g >= 0) chk("bram_addra", 64'(bram_addra), 64'(ga));
    else if (last_known) chk("bram_addra_hold", 64'(bram_addra), 64'(exp_last));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    chk("rsp_id", 64'(rsp_id), 64'(exp_id));
    chk("rsp_err", 64'(rsp_err), 64'(exp_err));
    if (exp_rv) chk("rsp_data", 64'(rsp_data), 64'(exp_data));
    @(posedge clka);
    if (g >= 0) begin exp_last = ga; last_known = 1'b1; end
    last_acc = acc ? g : -1;
    if (rsta) begin
      exp_rv = 0; exp_id = 0; exp_err = 0; last_g = NR - 1;
    end else if (acc) begin
      exp_rv = 1; exp_id = g; exp_err = (ga >= DEPTH);
      exp_data = exp_err ? 32'h0 : bram_fn(ga);
      last_g = g;
      acc_log.push_back(g);
    end else if (exp_rv && rsp_ready) begin
      exp_rv = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rsta = 1'b1;
    cycle();
    rsta = 1'b0;
  endtask

  initial begin
    rsta = 1'b1; req_valid = '0; req_addr = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clka);
    #1;
    exp_rv = 0; exp_id = 0; exp_err = 0; last_g = NR - 1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset_rsp_id", 64'(rsp_id), 64'h0);
    chk("reset_rsp_err", 64'(rsp_err), 64'h0);
    chk("reset_req_ready", 64'(req_ready), 64'h0);
    chk("reset_bram_ena", 64'(bram_ena), 64'h0);
    rsta = 1'b0;

    // Test 1: single lookup
    set_addr(0, 32'h10); req_valid = 4'b0001;
    cycle();
    chk("t1_accept", 64'(last_acc), 64'h0);
    chk("t1_data", 64'(rsp_data), 64'hDEADBEEF);
    req_valid = 4'b0000;
    cycle();

    // Test 2: all requesters valid, full throughput
    do_reset();
    for (int i = 0; i < NR; i++) set_addr(i, 32'(i * 256 + 5));
    acc_log.delete();
    req_valid = 4'b1111;
    repeat (8) cycle();
    req_valid = 4'b0000;
    chk("t2_count", 64'(acc_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < acc_log.size(); i++) chk("t2_order", 64'(acc_log[i]), 64'(i % NR));
    cycle();

    // Test 3: back-pressure
    req_valid = 4'b0001; rsp_ready = 1'b0;
    cycle();
    req_valid = 4'b0010;
    repeat (3) cycle();
    rsp_ready = 1'b1;
    cycle();
    chk("t3_accept_on_ready", 64'(last_acc), 64'h1);
    req_valid = 4'b0000;
    cycle();

    // Test 4: out-of-range and last legal address
    set_addr(1, 32'd32768); req_valid = 4'b0010;
    cycle();
    req_valid = 4'b0000;
    cycle();
    set_addr(1, 32'd32767); req_valid = 4'b0010;
    cycle();
    req_valid = 4'b0000;
    cycle();

    // Test 5: reset right after an accept
    req_valid = 4'b0100;
    cycle();
    req_valid = 4'b0000;
    do_reset();
    req_valid = 4'b0101;
    cycle();
    chk("t5_req0_wins", 64'(last_acc), 64'h0);
    req_valid = 4'b0000;
    cycle();

    // Test 6: requester 3 withdraws while stalled
    rsp_ready = 1'b0; req_valid = 4'b0001;
    cycle();
    req_valid = 4'b1000;
    cycle();
    chk("t6_no_accept", 64'($signed(last_acc)), 64'($signed(-1)));
    req_valid = 4'b0000; rsp_ready = 1'b1;
    repeat (2) cycle();
    req_valid = 4'b1001;
    cycle();
    chk("t6_ptr_kept", 64'(last_acc), 64'h3);
    req_valid = 4'b0000;
    cycle();

    // Randomized traffic; addresses are held until accepted
    for (int n = 0; n < 400; n++) begin
      rsta = ($urandom_range(0, 49) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      req_valid = 4'($urandom);
      cycle();
      if (last_acc >= 0) begin
        case ($urandom_range(0, 3))
          0: set_addr(last_acc, 32'($urandom_range(0, DEPTH - 1)));
          1: set_addr(last_acc, 32'd32768);
          2: set_addr(last_acc, 32'd32767);
          default: set_addr(last_acc, $urandom);
        endcase
      end
    end
    rsta = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
